// File: rtl/pdm_decoder_pkg.sv
// Shared types and CIC sizing helpers for the PDM decoder.
package pdm_decoder_pkg;

  localparam int AMPLITUDE_BITS = 12;
  typedef logic [AMPLITUDE_BITS-1:0] amplitude;

  localparam int CIC_ORDER      = 3;
  localparam int PDM_DECIMATION = 256;

  // Register width that keeps an order-N CIC exact under modulo arithmetic.
  function automatic int cic_width(input int order, input int log2r);
    return order * log2r + 1;
  endfunction

endpackage

// File: rtl/pdm_decoder_comb.sv
// One CIC differentiator stage: dout = din - previous sampled din; the delay advances only on en.
module cic_comb #(
  parameter int W = 25
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] dly;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dly <= '0;
    end else if (en) begin
      dly <= din;
    end
  end

  // Modulo subtraction; integrator wrap cancels out here by design.
  assign dout = din - dly;

endmodule

// File: rtl/pdm_decoder.sv
// 3rd-order CIC PDM-to-amplitude decoder; out/out_valid follow the wrapping bit by two edges, input never stalls.
// Build option PDM_DECODER_SETTLE_EN hides the first three decimated samples after reset.
module pdm_decoder
  import pdm_decoder_pkg::*;
#(
  parameter int NBITS      = AMPLITUDE_BITS,
  parameter int DECIMATION = PDM_DECIMATION
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  output logic [NBITS-1:0] out,
  output logic             out_valid
);

  localparam int L = $clog2(DECIMATION);
  localparam int W = cic_width(CIC_ORDER, L);
  localparam logic [W-1:0] FULL_SCALE = {1'b1, {(W-1){1'b0}}};

  if (DECIMATION < 4 || (DECIMATION & (DECIMATION - 1)) != 0 ||
      DECIMATION < (1 << (NBITS / 3)) || NBITS > 3 * L) begin : g_bad_params
    $error("pdm_decoder: DECIMATION %0d illegal for NBITS %0d", DECIMATION, NBITS);
  end

  logic [W-1:0]     i1, i2, i3;
  logic [W-1:0]     i1_nxt, i2_nxt, i3_nxt;
  logic [L-1:0]     cnt;
  logic             wrap, tick, tick_d, show;
  logic [W-1:0]     c1, c2, c3;
  logic [NBITS-1:0] sample, sample_q;

  always_comb begin
    i1_nxt = i1 + {{(W-1){1'b0}}, din};
    i2_nxt = i2 + i1_nxt;
    i3_nxt = i3 + i2_nxt;
  end

  assign wrap = din_valid && (&cnt);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i1   <= '0;
      i2   <= '0;
      i3   <= '0;
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      if (din_valid) begin
        i1  <= i1_nxt;
        i2  <= i2_nxt;
        i3  <= i3_nxt;
        cnt <= cnt + L'(1);
      end
    end
  end

  cic_comb #(.W(W)) u_comb1 (.clock(clock), .reset(reset), .en(tick), .din(i3), .dout(c1));
  cic_comb #(.W(W)) u_comb2 (.clock(clock), .reset(reset), .en(tick), .din(c1), .dout(c2));
  cic_comb #(.W(W)) u_comb3 (.clock(clock), .reset(reset), .en(tick), .din(c2), .dout(c3));

  // Full-scale input lands exactly on 2^(3L), one past the top of the slice.
  always_comb begin
    sample = c3[W-2 -: NBITS];
    if (c3 == FULL_SCALE) begin
      sample = '1;
    end
  end

  if (3 * L > NBITS) begin : g_lsbs
    logic unused_lsbs;
    assign unused_lsbs = ^c3[W-2-NBITS:0];
  end

`ifdef PDM_DECODER_SETTLE_EN
  logic [1:0] settle;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      settle <= '0;
    end else if (tick_d && settle != 2'd3) begin
      settle <= settle + 2'd1;
    end
  end

  assign show = (settle == 2'd3);
`else
  assign show = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_d    <= 1'b0;
      sample_q  <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      tick_d    <= tick;
      out_valid <= tick_d && show;
      if (tick) begin
        sample_q <= sample;
      end
      if (tick_d && show) begin
        out <= sample_q;
      end
    end
  end

endmodule

// File: tb/tb_pdm_decoder.sv
// Directed bench: a DECIMATION=256 decoder plus a DECIMATION=16 twin used for the integrator-wrap run.
module tb_pdm_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        din_valid = 1'b0;
  logic        din = 1'b0;
  logic [11:0] out, out2;
  logic        out_valid, out_valid2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc = 0;
  int consec = 0;
  logic prev_vld = 1'b0;
  int          p_cyc[$];
  logic [11:0] p_val[$];
  int          q_cyc[$];
  logic [11:0] q_val[$];

  pdm_decoder #(.NBITS(12), .DECIMATION(256)) dut (
    .clock(clock), .reset(reset), .din_valid(din_valid), .din(din),
    .out(out), .out_valid(out_valid)
  );

  pdm_decoder #(.NBITS(12), .DECIMATION(16)) dut16 (
    .clock(clock), .reset(reset), .din_valid(din_valid), .din(din),
    .out(out2), .out_valid(out_valid2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    cyc = 0;
    acc = 0;
    prev_vld = 1'b0;
    p_cyc.delete();
    p_val.delete();
    q_cyc.delete();
    q_val.delete();
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    din = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    clear();
  endtask

  // mode 0: zeros, 1: ones, 2: alternating per accepted bit. duty: one valid every 'duty' cycles.
  task automatic run(input int n, input int mode, input int duty);
    for (int i = 0; i < n; i++) begin
      din_valid = ((i % duty) == 0);
      din = (mode == 1) ? 1'b1 : (mode == 2) ? acc[0] : 1'b0;
      @(posedge clock);
      #1;
      cyc++;
      if (din_valid) acc++;
      if (out_valid) begin
        p_cyc.push_back(cyc);
        p_val.push_back(out);
        if (prev_vld) consec++;
      end
      prev_vld = out_valid;
      if (out_valid2) begin
        q_cyc.push_back(cyc);
        q_val.push_back(out2);
      end
    end
  endtask

  function automatic int bad_spacing(input int gap, input bit use16);
    int n = 0;
    if (use16) begin
      for (int k = 1; k < q_cyc.size(); k++) if (q_cyc[k] - q_cyc[k-1] != gap) n++;
    end else begin
      for (int k = 1; k < p_cyc.size(); k++) if (p_cyc[k] - p_cyc[k-1] != gap) n++;
    end
    return n;
  endfunction

  initial begin
    int nbad;

    #2;
    chk("reset_out", int'(out), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    @(posedge clock);
    #1 reset = 1'b1;
    clear();

    // Constant zeros
    run(1030, 0, 1);
    chk("zeros_count", p_cyc.size(), 4);
    if (p_cyc.size() > 0) chk("zeros_first_cycle", p_cyc[0], 258);
    nbad = 0;
    foreach (p_val[k]) if (p_val[k] !== 12'h000) nbad++;
    chk("zeros_values", nbad, 0);
    chk("zeros_spacing", bad_spacing(256, 1'b0), 0);

    // Constant ones, long enough to wrap the R=16 twin's 13-bit integrators
    do_reset();
    run(9300, 1, 1);
    chk("ones_count", p_cyc.size(), 36);
    if (p_cyc.size() >= 3) begin
      chk("ones_first_cycle", p_cyc[0], 258);
      chk("ones_pulse0", int'(p_val[0]), 12'h2B2);
      chk("ones_pulse1", int'(p_val[1]), 12'hD5D);
      nbad = 0;
      for (int k = 2; k < p_val.size(); k++) if (p_val[k] !== 12'hFFF) nbad++;
      chk("ones_steady", nbad, 0);
    end
    chk("ones_spacing", bad_spacing(256, 1'b0), 0);
    chk("ones_hold_out", int'(out), 12'hFFF);
    chk("ones_hold_valid", int'(out_valid), 0);
    chk("r16_count", q_cyc.size(), 581);
    if (q_cyc.size() >= 3) begin
      chk("r16_first_cycle", q_cyc[0], 18);
      chk("r16_pulse0", int'(q_val[0]), 12'h330);
      chk("r16_pulse1", int'(q_val[1]), 12'hDD0);
      nbad = 0;
      for (int k = 2; k < q_val.size(); k++) if (q_val[k] !== 12'hFFF) nbad++;
      chk("r16_wrap_steady", nbad, 0);
    end
    chk("r16_spacing", bad_spacing(16, 1'b1), 0);

    // Alternating bits at 1/3 valid duty
    do_reset();
    run(3850, 2, 3);
    chk("alt_count", p_cyc.size(), 5);
    if (p_cyc.size() == 5) begin
      chk("alt_first_cycle", p_cyc[0], 768);
      chk("alt_pulse2", int'(p_val[2]), 12'h800);
      chk("alt_pulse3", int'(p_val[3]), 12'h800);
      chk("alt_pulse4", int'(p_val[4]), 12'h800);
    end
    chk("alt_spacing", bad_spacing(768, 1'b0), 0);

    // Reset at bit 100 of the second frame
    do_reset();
    run(356, 1, 1);
    chk("midrst_pre_out", int'(out), 12'h2B2);
    reset = 1'b0;
    #1;
    chk("midrst_async_out", int'(out), 0);
    chk("midrst_async_valid", int'(out_valid), 0);
    din_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    clear();
    run(600, 1, 1);
    chk("midrst_count", p_cyc.size(), 2);
    if (p_cyc.size() > 0) begin
      chk("midrst_first_cycle", p_cyc[0], 258);
      chk("midrst_first_value", int'(p_val[0]), 12'h2B2);
    end

    chk("no_back_to_back", consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
